// File: rtl/mcpu_pkg.sv
// Shared encodings for the multicycle micro CPU: ISA opcodes/functs, FSM states, ALU ops.
package mcpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   function automatic logic legal_instr(input logic [5:0] op, input logic [5:0] funct);
      logic ok;
      case (op)
         OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_SLT);
         OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
      alu_op_t op;
      case (funct)
         FN_SUB:  op = ALU_SUB;
         FN_AND:  op = ALU_AND;
         FN_OR:   op = ALU_OR;
         FN_SLT:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// Register file: two async read ports, one debug read port, one enable-gated sync write port.
// Register 0 and indices at or above REG_COUNT always read zero.
module mcpu_regfile #(
   parameter int DATA_W    = 32,
   parameter int REG_COUNT = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [4:0]        rs_addr,
   input  logic [4:0]        rt_addr,
   input  logic [4:0]        dbg_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              we,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int IDX_W = $clog2(REG_COUNT);

   logic [DATA_W-1:0] regs [REG_COUNT];

   function automatic logic valid_idx(input logic [4:0] a);
      return (a != 5'd0) && (32'(a) < REG_COUNT);
   endfunction

   always_comb begin
      rs_data  = '0;
      rt_data  = '0;
      dbg_data = '0;
      if (valid_idx(rs_addr))  rs_data  = regs[rs_addr[IDX_W-1:0]];
      if (valid_idx(rt_addr))  rt_data  = regs[rt_addr[IDX_W-1:0]];
      if (valid_idx(dbg_addr)) dbg_data = regs[dbg_addr[IDX_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (enable && we && valid_idx(wr_addr)) begin
         regs[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/mcpu_multicycle_core.sv
// Multicycle MIPS-subset core with one shared req/ready memory port and debug taps.
// Optional MCPU_SINGLE_STEP_EN adds a step input that releases one instruction per rising edge.
//
// state   | meaning
// FETCH   | request instruction at PC, IR/PC update on ready
// DECODE  | latch rs/rt values and sign-extended immediate, reject illegal encodings
// EXEC    | ALU op, address calc, branch/jump resolution
// MEM     | data load/store on the shared port
// WB      | register write-back
// TRAP    | illegal instruction, sticky until reset
module mcpu_multicycle_core
   import mcpu_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                REG_COUNT = 32,
   parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
`ifdef MCPU_SINGLE_STEP_EN
   input  logic              step,
`endif
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] pc_out,
   output logic [2:0]        state_out,
   output logic [31:0]       instr_out,
   output logic [DATA_W-1:0] alu_out,
   output logic              trap,
   input  logic [4:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            state;
   logic [DATA_W-1:0] pc, a_reg, b_reg, imm_reg, alu_reg, mdr;
   logic [31:0]       ir;
   logic [DATA_W-1:0] rs_data, rt_data, alu_b, alu_y, j_target;
   logic signed [15:0] imm16;
   alu_op_t           alu_op;
   logic              fetch_ok, xfer;

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd;
   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign funct = ir[5:0];
   assign imm16 = ir[15:0];

   // Reset gates the request combinationally so an in-flight access is abandoned at once.
   assign mem_req   = reset && enable && (((state == ST_FETCH) && fetch_ok) || (state == ST_MEM));
   assign mem_we    = mem_req && (state == ST_MEM) && (op == OP_SW);
   assign mem_addr  = (state == ST_MEM) ? alu_reg : pc;
   assign mem_wdata = b_reg;
   assign xfer      = mem_req && mem_ready;

   assign pc_out    = pc;
   assign state_out = state;
   assign instr_out = ir;
   assign alu_out   = alu_reg;
   assign trap      = (state == ST_TRAP);

   generate
      if (DATA_W > 28) begin : g_jwide
         assign j_target = {pc[DATA_W-1:28], ir[25:0], 2'b00};
      end else begin : g_jnarrow
         logic [27:0] j_full;
         assign j_full   = {ir[25:0], 2'b00};
         assign j_target = j_full[DATA_W-1:0];
      end
   endgenerate

   always_comb begin
      alu_op = ALU_ADD;
      alu_b  = imm_reg;
      if (op == OP_RTYPE) begin
         alu_op = funct_to_alu(funct);
         alu_b  = b_reg;
      end
   end

   always_comb begin
      alu_y = '0;
      case (alu_op)
         ALU_ADD: alu_y = a_reg + alu_b;
         ALU_SUB: alu_y = a_reg - alu_b;
         ALU_AND: alu_y = a_reg & alu_b;
         ALU_OR:  alu_y = a_reg | alu_b;
         ALU_SLT: alu_y[0] = $signed(a_reg) < $signed(alu_b);
         default: alu_y = '0;
      endcase
   end

   mcpu_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_regfile (
      .clk      (clk),
      .rst_n    (reset),
      .enable   (enable),
      .rs_addr  (rs),
      .rt_addr  (rt),
      .dbg_addr (dbg_sel),
      .rs_data  (rs_data),
      .rt_data  (rt_data),
      .dbg_data (dbg_data),
      .we       (state == ST_WB),
      .wr_addr  ((op == OP_RTYPE) ? rd : rt),
      .wr_data  ((op == OP_LW) ? mdr : alu_reg)
   );

`ifdef MCPU_SINGLE_STEP_EN
   logic [2:0] step_sync;
   logic       armed;

   // Edges seen while an instruction is in flight are dropped: arming only happens in an idle FETCH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_sync <= '0;
         armed     <= 1'b0;
      end else begin
         step_sync <= {step_sync[1:0], step};
         if (enable) begin
            if ((state == ST_FETCH) && !armed && step_sync[1] && !step_sync[2]) armed <= 1'b1;
            else if ((state == ST_FETCH) && xfer)                              armed <= 1'b0;
         end
      end
   end
   assign fetch_ok = armed;
`else
   assign fetch_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_FETCH;
         pc      <= RESET_PC;
         ir      <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         imm_reg <= '0;
         alu_reg <= '0;
         mdr     <= '0;
      end else if (enable) begin
         case (state)
            ST_FETCH: if (xfer) begin
               ir    <= 32'(mem_rdata);
               pc    <= pc + DATA_W'(4);
               state <= ST_DECODE;
            end
            ST_DECODE: begin
               a_reg   <= rs_data;
               b_reg   <= rt_data;
               imm_reg <= DATA_W'(imm16);
               state   <= legal_instr(op, funct) ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
               case (op)
                  OP_RTYPE, OP_ADDI: begin
                     alu_reg <= alu_y;
                     state   <= ST_WB;
                  end
                  OP_LW, OP_SW: begin
                     alu_reg <= alu_y;
                     state   <= ST_MEM;
                  end
                  OP_BEQ: begin
                     if (a_reg == b_reg) pc <= pc + (imm_reg << 2);
                     state <= ST_FETCH;
                  end
                  OP_J: begin
                     pc    <= j_target;
                     state <= ST_FETCH;
                  end
                  default: state <= ST_TRAP;
               endcase
            end
            ST_MEM: if (xfer) begin
               if (op == OP_LW) begin
                  mdr   <= mem_rdata;
                  state <= ST_WB;
               end else begin
                  state <= ST_FETCH;
               end
            end
            ST_WB:   state <= ST_FETCH;
            ST_TRAP: state <= ST_TRAP;
            default: state <= ST_TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_mcpu_multicycle_core.sv
// Directed bench for mcpu_multicycle_core with a shared word memory and programmable ready latency.
module tb_mcpu_multicycle_core;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic        mem_req, mem_we, mem_ready, trap;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instr_out, alu_out, dbg_data;
   logic [2:0]  state_out;
   logic [4:0]  dbg_sel = 5'd0;
`ifdef MCPU_SINGLE_STEP_EN
   logic        step = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] prog [256];
   logic [31:0] dmem [256];
   bit          dvalid [256];
   logic        mem_clr = 1'b1;
   int          lat = 0;
   int          wcnt = 0;
   logic [7:0]  widx;

   always #5 clk = ~clk;

   mcpu_multicycle_core dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
`ifdef MCPU_SINGLE_STEP_EN
      .step      (step),
`endif
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc_out    (pc_out),
      .state_out (state_out),
      .instr_out (instr_out),
      .alu_out   (alu_out),
      .trap      (trap),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data)
   );

   // Ready is asserted once a request has waited lat cycles; with lat=0 it is tied high.
   assign widx      = mem_addr[9:2];
   assign mem_ready = (wcnt >= lat);
   assign mem_rdata = dvalid[widx] ? dmem[widx] : prog[widx];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) dvalid[i] <= 1'b0;
         wcnt <= 0;
      end else if (mem_req && mem_ready) begin
         wcnt <= 0;
         if (mem_we) begin
            dmem[widx]   <= mem_wdata;
            dvalid[widx] <= 1'b1;
         end
      end else if (mem_req) begin
         wcnt <= wcnt + 1;
      end else begin
         wcnt <= 0;
      end
   end

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
      dbg_sel = idx;
      #1;
      check(tag, dbg_data, exp);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 32'h0;
   endtask

   task automatic do_reset(input int l);
      @(negedge clk);
      reset   = 1'b0;
      mem_clr = 1'b1;
      lat     = l;
      repeat (3) @(negedge clk);
      mem_clr = 1'b0;
      reset   = 1'b1;
   endtask

   // Counts clock edges from the start of a FETCH until the core is back in FETCH.
   task automatic run_instr(input string tag, input int exp_cyc);
      int cyc;
      bit left;
      cyc  = 0;
      left = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cyc++;
         if (state_out !== 3'd0) left = 1'b1;
         else if (left) break;
      end
      check(tag, cyc, exp_cyc);
   endtask

   task automatic wait_trap(input string tag);
      for (int i = 0; i < 500 && trap !== 1'b1; i++) @(negedge clk);
      check(tag, 32'(trap), 32'd1);
   endtask

   initial begin
      bit stable;

      // Reset and ALU sequence, zero-wait memory
      clear_prog();
      prog[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
      prog[1] = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);
      prog[2] = enc_r(5'd1, 5'd2, 5'd3, 6'b100000);
      prog[3] = enc_r(5'd2, 5'd1, 5'd4, 6'b101010);
      prog[4] = enc_r(5'd2, 5'd1, 5'd5, 6'b100010);
      prog[5] = enc_r(5'd1, 5'd2, 5'd7, 6'b100100);
      prog[6] = enc_r(5'd1, 5'd2, 5'd8, 6'b100101);
      prog[7] = enc_i(6'b001000, 5'd0, 5'd0, 16'd7);
      repeat (3) @(negedge clk);
      check("rst_pc", pc_out, 32'h0);
      check("rst_state", 32'(state_out), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_trap", 32'(trap), 32'd0);
      check("rst_ir", instr_out, 32'h0);
      mem_clr = 1'b0;
      reset   = 1'b1;
      #1;
      check("start_req", 32'(mem_req), 32'd1);
      check("start_addr", mem_addr, 32'h0);
      for (int i = 0; i < 8; i++) run_instr($sformatf("alu_cyc%0d", i), 4);
      wait_trap("alu_end_trap");
      check("alu_trap_pc", pc_out, 32'h24);
      check_reg("r1", 5'd1, 32'd5);
      check_reg("r2", 5'd2, 32'hFFFF_FFFD);
      check_reg("r3_add", 5'd3, 32'd2);
      check_reg("r4_slt", 5'd4, 32'd1);
      check_reg("r5_sub", 5'd5, 32'hFFFF_FFF8);
      check_reg("r7_and", 5'd7, 32'd5);
      check_reg("r8_or", 5'd8, 32'hFFFF_FFFD);
      check_reg("r0_zero", 5'd0, 32'd0);

      // Store/load with three wait cycles on every access
      clear_prog();
      prog[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
      prog[1] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0080);
      prog[2] = enc_i(6'b100011, 5'd0, 5'd6, 16'h0080);
      do_reset(3);
      run_instr("addi_wait_cyc", 7);
      for (int i = 0; i < 20 && state_out !== 3'd3; i++) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("sw_addr%0d", k), mem_addr, 32'h80);
         check($sformatf("sw_ctl%0d", k), {30'd0, mem_req, mem_we}, 32'd3);
         check($sformatf("sw_wdata%0d", k), mem_wdata, 32'd5);
      end
      @(negedge clk);
      check("sw_done_state", 32'(state_out), 32'd0);
      check("sw_stored", dmem[32], 32'd5);
      // lw: 4 fetch + decode + exec + 4 mem + wb
      run_instr("lw_wait_cyc", 11);
      wait_trap("mem_end_trap");
      check_reg("r6_lw", 5'd6, 32'd5);

      // Control flow
      clear_prog();
      prog[0]  = enc_i(6'b001000, 5'd0, 5'd1, 16'd1);
      prog[1]  = enc_i(6'b001000, 5'd0, 5'd2, 16'd2);
      prog[2]  = enc_i(6'b001000, 5'd0, 5'd3, 16'd3);
      prog[3]  = enc_i(6'b001000, 5'd0, 5'd4, 16'd4);
      prog[4]  = enc_i(6'b000100, 5'd1, 5'd1, 16'd2);
      prog[5]  = enc_i(6'b001000, 5'd0, 5'd10, 16'h55);
      prog[6]  = enc_i(6'b001000, 5'd0, 5'd10, 16'h55);
      prog[7]  = enc_i(6'b000100, 5'd1, 5'd2, 16'd5);
      prog[8]  = {6'b000010, 26'h40};
      prog[64] = enc_i(6'b001000, 5'd0, 5'd11, 16'h77);
      do_reset(0);
      for (int i = 0; i < 4; i++) run_instr($sformatf("cf_addi%0d", i), 4);
      run_instr("beq_taken_cyc", 3);
      check("beq_taken_pc", pc_out, 32'h1C);
      run_instr("beq_not_cyc", 3);
      check("beq_not_pc", pc_out, 32'h20);
      run_instr("j_cyc", 3);
      check("j_pc", pc_out, 32'h100);
      wait_trap("cf_end_trap");
      check_reg("r10_skipped", 5'd10, 32'd0);
      check_reg("r11_target", 5'd11, 32'h77);

      // Illegal opcode trap
      clear_prog();
      prog[0] = 32'hFC00_0000;
      do_reset(0);
      wait_trap("trap_set");
      check("trap_state", 32'(state_out), 32'd5);
      check("trap_req", 32'(mem_req), 32'd0);
      check("trap_pc", pc_out, 32'h4);
      stable = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (pc_out !== 32'h4 || state_out !== 3'd5 || mem_req !== 1'b0) stable = 1'b0;
      end
      check("trap_sticky", 32'(stable), 32'd1);
      reset = 1'b0;
      #1;
      check("trap_cleared", 32'(trap), 32'd0);
      check("trap_rst_state", 32'(state_out), 32'd0);

      // Enable freeze during lw MEM with ready high
      clear_prog();
      prog[0] = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
      prog[1] = enc_i(6'b101011, 5'd0, 5'd1, 16'h0084);
      prog[2] = enc_i(6'b100011, 5'd0, 5'd7, 16'h0084);
      do_reset(0);
      run_instr("frz_addi_cyc", 4);
      run_instr("frz_sw_cyc", 4);
      for (int i = 0; i < 20 && state_out !== 3'd3; i++) @(negedge clk);
      enable = 1'b0;
      stable = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (state_out !== 3'd3 || mem_req !== 1'b0) stable = 1'b0;
      end
      check("frz_hold", 32'(stable), 32'd1);
      check("frz_pc", pc_out, 32'h0C);
      check("frz_addr", mem_addr, 32'h84);
      check_reg("frz_r7_unwritten", 5'd7, 32'd0);
      enable = 1'b1;
      #1;
      check("frz_resume_req", 32'(mem_req), 32'd1);
      wait_trap("frz_end_trap");
      check_reg("frz_r7_loaded", 5'd7, 32'd5);

      // Reset in the middle of a waiting fetch
      do_reset(3);
      @(negedge clk);
      check("midrst_req_before", 32'(mem_req), 32'd1);
      reset = 1'b0;
      #1;
      check("midrst_req_drop", 32'(mem_req), 32'd0);
      check("midrst_pc", pc_out, 32'h0);

`ifdef MCPU_SINGLE_STEP_EN
      clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = enc_i(6'b001000, 5'd1, 5'd1, 16'd1);
      do_reset(0);
      repeat (5) @(negedge clk);
      check("step_idle_req", 32'(mem_req), 32'd0);
      repeat (3) begin
         step = 1'b1;
         repeat (3) @(negedge clk);
         step = 1'b0;
         repeat (12) @(negedge clk);
      end
      check_reg("step_r1", 5'd1, 32'd3);
      check("step_pc", pc_out, 32'h0C);
      check("step_idle_after", 32'(mem_req), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
